program_loader: RTL and testbench

- Upstream of the fetch stage. Receives a program as a byte stream from the debug UART receiver.
- Assembles each group of 4 bytes into a 32-bit instruction word and writes it into instruction memory. The write uses the fetch stage's load port: load-program select, write address, write data and write strobe.
- Holds the fetch stage in load mode until a halt word is received. Then it releases the processor.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/byte_assembler.sv | 40 ++++
 rtl/program_loader.sv | 137 +++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-load path in front of the fetch stage.
// Contents: loader state encoding, instruction width, default halt word.
// No ports; imported by program_loader and byte_assembler.
package pipeline_pkg;

    localparam int          INSTR_W           = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs four consecutive bytes (first byte = MSB) into one 32-bit instruction word.
// Ports: clk/rst, i_clear (sync clear), i_enable + i_valid/i_byte (byte input),
//        o_word (word including the current byte), o_word_ready (4th-byte pulse), o_byte_count.
module byte_assembler
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_word_ready,
    output logic [1:0]         o_byte_count
);

    logic [INSTR_W-1:0] r_shift;
    logic [1:0]         r_count;
    logic               w_shift;

    assign w_shift = i_enable && i_valid;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_count <= 2'd0;
        end else if (w_shift) begin
            r_shift <= {r_shift[INSTR_W-9:0], i_byte};
            r_count <= r_count + 2'd1;   // wraps 3 -> 0 on the 4th byte
        end
    end

    // The completed word is presented in the same cycle as its 4th byte so the
    // loader can latch it on the capturing edge without an extra stage.
    assign o_word       = {r_shift[INSTR_W-9:0], i_byte};
    assign o_word_ready = w_shift && (r_count == 2'd3);
    assign o_byte_count = r_count;

endmodule

// File: rtl/program_loader.sv
// Loads a program from a UART byte stream into instruction memory through the
// fetch stage's load port, holding fetch in load mode until the halt word is written.
// Ports: clk/rst, inStart, inRxData/inRxValid in; outLoadProgram, outAddress,
//        outDataInstruction, outWrInstruction, outWordCount, outDone, outError out.
// Optional: define LOADER_TIMEOUT_EN to abort a stalled load after TIMEOUT_CYCLES idle cycles.
module program_loader
    import pipeline_pkg::*;
#(
    parameter int          MEM_DEPTH      = 256,
    parameter logic [31:0] HALT_WORD      = HALT_WORD_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1_000_000
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               inStart,
    input  logic [7:0]         inRxData,
    input  logic               inRxValid,
    output logic               outLoadProgram,
    output logic [31:0]        outAddress,
    output logic [INSTR_W-1:0] outDataInstruction,
    output logic               outWrInstruction,
    output logic [31:0]        outWordCount,
    output logic               outDone,
    output logic               outError
);

    localparam logic [31:0] LAST_INDEX = 32'(MEM_DEPTH - 1);

    loader_state_t      r_state;
    loader_state_t      w_next_state;
    logic [31:0]        r_address;
    logic [31:0]        r_word_count;
    logic [INSTR_W-1:0] r_data;

    logic               w_start_ok;
    logic               w_in_recv;
    logic [INSTR_W-1:0] w_asm_word;
    logic               w_word_ready;
    logic [1:0]         w_byte_count;
    logic               w_timeout;

    assign w_in_recv  = (r_state == ST_RECV);
    assign w_start_ok = inStart &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_enable     (w_in_recv),
        .i_valid      (inRxValid),
        .i_byte       (inRxData),
        .o_word       (w_asm_word),
        .o_word_ready (w_word_ready),
        .o_byte_count (w_byte_count)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] r_idle;

    // Counts idle RECV cycles; outside RECV it sits at zero so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || !w_in_recv || inRxValid) begin
            r_idle <= '0;
        end else if (r_idle != TIMEOUT_LIMIT) begin
            r_idle <= r_idle + 32'd1;
        end
    end

    // A load that has not started yet may wait forever; once any byte or word
    // has arrived, a stalled stream is abandoned without writing the partial word.
    assign w_timeout = w_in_recv && !inRxValid && (r_idle == TIMEOUT_LIMIT) &&
                       ((w_byte_count != 2'd0) || (r_word_count != 32'd0));
`else
    localparam logic [31:0] UNUSED_TIMEOUT = 32'(TIMEOUT_CYCLES);
    logic w_unused_byte_count;

    assign w_unused_byte_count = ^w_byte_count;
    assign w_timeout           = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (inStart) w_next_state = ST_RECV;
            end
            ST_RECV: begin
                if (w_word_ready)   w_next_state = ST_WRITE;
                else if (w_timeout) w_next_state = ST_ERROR;
            end
            ST_WRITE: begin
                // Halt wins over memory-full: a halt in the last slot is a valid program.
                if (r_data == HALT_WORD)                         w_next_state = ST_DONE;
                else if (r_word_count + 32'd1 == 32'(MEM_DEPTH)) w_next_state = ST_ERROR;
                else                                             w_next_state = ST_RECV;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_word_count <= '0;
            r_data       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_address    <= '0;
                r_word_count <= '0;
            end
            if (w_word_ready) begin
                r_data <= w_asm_word;
            end
            if (r_state == ST_WRITE) begin
                r_word_count <= r_word_count + 32'd1;
                // Saturate so the index never points past the last memory word.
                if (r_address != LAST_INDEX) begin
                    r_address <= r_address + 32'd1;
                end
            end
        end
    end

    assign outLoadProgram     = (r_state == ST_RECV) || (r_state == ST_WRITE);
    assign outWrInstruction   = (r_state == ST_WRITE);
    assign outDone            = (r_state == ST_DONE);
    assign outError           = (r_state == ST_ERROR);
    assign outAddress         = r_address;
    assign outWordCount       = r_word_count;
    assign outDataInstruction = r_data;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          TO    = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        inStart;
    logic [7:0]  inRxData;
    logic        inRxValid;
    logic        outLoadProgram;
    logic [31:0] outAddress;
    logic [31:0] outDataInstruction;
    logic        outWrInstruction;
    logic [31:0] outWordCount;
    logic        outDone;
    logic        outError;

    always #5 clk = ~clk;

    program_loader #(
        .MEM_DEPTH      (DEPTH),
        .HALT_WORD      (HALT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .inStart            (inStart),
        .inRxData           (inRxData),
        .inRxValid          (inRxValid),
        .outLoadProgram     (outLoadProgram),
        .outAddress         (outAddress),
        .outDataInstruction (outDataInstruction),
        .outWrInstruction   (outWrInstruction),
        .outWordCount       (outWordCount),
        .outDone            (outDone),
        .outError           (outError)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write strobe seen on the memory port, in order.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    always @(negedge clk) begin
        if (outWrInstruction === 1'b1) begin
            obs_addr.push_back(outAddress);
            obs_data.push_back(outDataInstruction);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        inRxData  = b;
        inRxValid = 1'b1;
        tick();
        inRxValid = 1'b0;
        inRxData  = 8'h00;
    endtask

    task automatic pulse_start();
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " loadprog"}, 32'(outLoadProgram), 32'd0);
        check({tag, " addr"},     outAddress, 32'd0);
        check({tag, " data"},     outDataInstruction, 32'd0);
        check({tag, " wr"},       32'(outWrInstruction), 32'd0);
        check({tag, " count"},    outWordCount, 32'd0);
        check({tag, " done"},     32'(outDone), 32'd0);
        check({tag, " error"},    32'(outError), 32'd0);
    endtask

    // Sends the given words after a start pulse; busy_byte >= 0 injects an
    // extra start pulse right after that byte index. The expected outcome is
    // derived from the loading rules: words are stored at consecutive indices
    // until the halt word (stored) or until the memory is full.
    task automatic run_load(input string tag, input logic [31:0] words[$], input int busy_byte);
        logic [31:0] exp_data[$];
        int          exp_done;
        int          exp_err;
        int          j;
        int          k;
        exp_done = 0;
        exp_err  = 0;
        foreach (words[i]) begin
            exp_data.push_back(words[i]);
            if (words[i] == HALT) begin
                exp_done = 1;
                break;
            end
            if (i + 1 == DEPTH) begin
                exp_err = 1;
                break;
            end
        end

        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        check({tag, " loadprog after start"}, 32'(outLoadProgram), 32'd1);
        check({tag, " addr after start"},     outAddress, 32'd0);

        j = 0;
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(words[i][31-8*b -: 8]);
                if (b == 3 && i < exp_data.size()) begin
                    check({tag, " strobe latency"}, 32'(outWrInstruction), 32'd1);
                    check({tag, " strobe data"},    outDataInstruction, words[i]);
                end
                if (j == busy_byte) pulse_start();
                j++;
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        k = 0;
        while (!(outDone || outError) && k < 50) begin
            tick();
            k++;
        end
        check({tag, " finished"}, 32'(outDone | outError), 32'd1);
        repeat (2) tick();

        check({tag, " n_writes"}, obs_addr.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s w%0d addr", tag, i), obs_addr[i], 32'(i));
            check($sformatf("%s w%0d data", tag, i), obs_data[i], exp_data[i]);
        end
        check({tag, " done"},     32'(outDone), 32'(exp_done));
        check({tag, " error"},    32'(outError), 32'(exp_err));
        check({tag, " count"},    outWordCount, exp_data.size());
        check({tag, " addr end"}, outAddress,
              (exp_data.size() > DEPTH - 1) ? 32'(DEPTH - 1) : 32'(exp_data.size()));
        check({tag, " loadprog"}, 32'(outLoadProgram), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        int          n;

        rst       = 1'b1;
        inStart   = 1'b0;
        inRxValid = 1'b0;
        inRxData  = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Bytes without a start are dropped.
        obs_addr.delete();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h11 * (i + 1));
            tick();
        end
        repeat (3) tick();
        check("idle bytes n_writes", obs_addr.size(), 32'd0);
        check_all_zero("idle bytes");

        w = '{32'h2001_0005, HALT};
        run_load("two_word", w, -1);

        w = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h0000_0005};
        run_load("overflow", w, -1);

        w = '{32'hA1B2_C3D4, 32'h0102_0304, HALT};
        run_load("busy_start", w, 1);

        // Reset in the middle of a word aborts it without a write.
        obs_addr.delete();
        pulse_start();
        send_byte(8'hDE);
        tick();
        send_byte(8'hAD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midreset n_writes", obs_addr.size(), 32'd0);
        check_all_zero("midreset");
        w = '{32'h5566_7788, HALT};
        run_load("after_reset", w, -1);

        for (int r = 0; r < 10; r++) begin
            w.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                w.push_back(($urandom_range(0, 4) == 0) ? HALT : $urandom());
            end
            w.push_back(HALT);
            run_load($sformatf("rand%0d", r), w, -1);
        end

        // Stalled partial word.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs_addr.delete();
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        repeat (TO + 5) tick();
        check("stall n_writes", obs_addr.size(), 32'd0);
`ifdef LOADER_TIMEOUT_EN
        check("stall error",    32'(outError), 32'd1);
        check("stall loadprog", 32'(outLoadProgram), 32'd0);
`else
        check("stall error",    32'(outError), 32'd0);
        check("stall loadprog", 32'(outLoadProgram), 32'd1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("final reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
